// File: rtl/menu_pkg.sv
// Shared types and constants for the menu bar controller and its display mux.
package menu_pkg;

  // Navigation FSM encoding
  typedef enum logic [1:0] {
    BROWSE      = 2'd0,
    RUN         = 2'd1,
    SCREENSAVER = 2'd2
  } state_t;

  // Display mode indices, as carried on active_mode / box_counter
  localparam logic [2:0] WAVE_PLAIN  = 3'd0;
  localparam logic [2:0] WAVE_SHADED = 3'd1;
  localparam logic [2:0] BAR         = 3'd2;
  localparam logic [2:0] RAIN        = 3'd3;
  localparam logic [2:0] PIKACHU_VOL = 3'd4;

  // Menu bar colours used by the downstream renderer
  localparam logic [15:0] MENU_COLOUR_BG  = 16'hAEDF;
  localparam logic [15:0] MENU_COLOUR_BOX = 16'hFAAE;
  localparam logic [15:0] MENU_COLOUR_HL  = 16'h10F2;

endpackage

// File: rtl/menu_nav_ctrl_if.sv
// Button/timer inputs and mux-select outputs of the menu controller.
// There is no valid/ready pair on this bus: inputs are sampled every rising
// clock edge, outputs are registered and valid every cycle; tick_en is a
// one-cycle strobe and mode_change a one-cycle pulse.
interface menu_nav_if;
  import menu_pkg::*;

  logic       tick_en;
  logic       pb_left;
  logic       pb_right;
  logic       pb_centre;
  logic       pb_down;
  logic       menu_switch;
  logic       switch_control_2;
  logic [2:0] box_counter;
  logic [2:0] active_mode;
  logic       menu_visible;
  logic       highlight_on;
  logic       screensaver_active;
  logic       mode_change;
  state_t     state_dbg;

  // Button / timer side
  modport master (
    output tick_en, pb_left, pb_right, pb_centre, pb_down,
           menu_switch, switch_control_2,
    input  box_counter, active_mode, menu_visible, highlight_on,
           screensaver_active, mode_change, state_dbg
  );

  // Controller side
  modport slave (
    input  tick_en, pb_left, pb_right, pb_centre, pb_down,
           menu_switch, switch_control_2,
    output box_counter, active_mode, menu_visible, highlight_on,
           screensaver_active, mode_change, state_dbg
  );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level: a held button
// produces a single one-cycle press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic btn_q;

  // Previous level, tracked every cycle regardless of lock state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign press = btn & ~btn_q;
endmodule

// File: rtl/menu_nav_ctrl.sv
// Menu bar navigation controller: turns button presses into box selection
// and mode commits, blinks the highlight and enters a screensaver on idle.
module menu_nav_ctrl
  import menu_pkg::*;
#(
  parameter int NUM_ITEMS  = 5,
  parameter int IDLE_TICKS = 3000,
  parameter int BLINK_HALF = 5
) (
  input logic       clk_menu,
  input logic       reset,
  menu_nav_if.slave bus
);
  localparam int IDLE_W  = $clog2(IDLE_TICKS + 1);
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [2:0]         BOX_MAX    = 3'(NUM_ITEMS - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic press_l, press_r, press_c, press_d, any_press, lock, nav_en;

  btn_edge u_edge_l (.clk(clk_menu), .rst(reset), .btn(bus.pb_left),   .press(press_l));
  btn_edge u_edge_r (.clk(clk_menu), .rst(reset), .btn(bus.pb_right),  .press(press_r));
  btn_edge u_edge_c (.clk(clk_menu), .rst(reset), .btn(bus.pb_centre), .press(press_c));
  btn_edge u_edge_d (.clk(clk_menu), .rst(reset), .btn(bus.pb_down),   .press(press_d));

  state_t              state, saved_state, state_next, saved_next;
  logic [2:0]          box_counter, active_mode, box_next, mode_next;
  logic                menu_visible, highlight_on, screensaver_active, mode_change;
  logic                commit, vis_next;
  logic [IDLE_W-1:0]   idle_cnt, idle_next;
  logic [BLINK_W-1:0]  blink_cnt;

  assign any_press = press_l | press_r | press_c | press_d;
  assign lock      = bus.switch_control_2;
  // Box navigation is live in BROWSE, or in RUN while the menu bar is shown
  assign nav_en    = (state == BROWSE) || bus.menu_switch;

  // One event per cycle: lock > screensaver exit > centre > down > left/right
  always_comb begin
    state_next = state;
    saved_next = saved_state;
    box_next   = box_counter;
    mode_next  = active_mode;
    idle_next  = idle_cnt;
    commit     = 1'b0;
    if (lock) begin
      idle_next = '0;
      if (state == SCREENSAVER) state_next = saved_state;
    end else if (state == SCREENSAVER) begin
      // Idle timer parked while the screensaver runs; wake press is consumed
      idle_next = '0;
      if (any_press) state_next = saved_state;
    end else begin
      if (press_c && nav_en) begin
        mode_next  = box_counter;
        commit     = 1'b1;
        state_next = RUN;
      end else if (press_d && state == RUN) begin
        state_next = BROWSE;
        box_next   = active_mode;
      end else if (nav_en && press_r && !press_l) begin
        if (box_counter < BOX_MAX) box_next = box_counter + 3'd1;
      end else if (nav_en && press_l && !press_r) begin
        if (box_counter != 3'd0) box_next = box_counter - 3'd1;
      end
      if (any_press) begin
        idle_next = '0;
      end else if (bus.tick_en) begin
        if (idle_cnt == IDLE_LAST) begin
          idle_next  = '0;
          saved_next = state;
          state_next = SCREENSAVER;
        end else begin
          idle_next = idle_cnt + 1'b1;
        end
      end
    end
    case (state_next)
      BROWSE:  vis_next = 1'b1;
      RUN:     vis_next = bus.menu_switch;
      default: vis_next = 1'b0;
    endcase
  end

  // Navigation FSM with registered outputs
  always_ff @(posedge clk_menu or posedge reset) begin
    if (reset) begin
      state              <= BROWSE;
      saved_state        <= BROWSE;
      box_counter        <= 3'd0;
      active_mode        <= 3'd0;
      idle_cnt           <= '0;
      mode_change        <= 1'b0;
      menu_visible       <= 1'b1;
      screensaver_active <= 1'b0;
    end else begin
      state              <= state_next;
      saved_state        <= saved_next;
      box_counter        <= box_next;
      active_mode        <= mode_next;
      idle_cnt           <= idle_next;
      mode_change        <= commit;
      menu_visible       <= vis_next;
      screensaver_active <= (state_next == SCREENSAVER);
    end
  end

  // Highlight blink; a box move restarts the phase with the highlight lit
  always_ff @(posedge clk_menu or posedge reset) begin
    if (reset) begin
      blink_cnt    <= '0;
      highlight_on <= 1'b1;
    end else if (box_next != box_counter) begin
      blink_cnt    <= '0;
      highlight_on <= 1'b1;
    end else if (bus.tick_en) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt    <= '0;
        highlight_on <= ~highlight_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign bus.box_counter        = box_counter;
  assign bus.active_mode        = active_mode;
  assign bus.menu_visible       = menu_visible;
  assign bus.highlight_on       = highlight_on;
  assign bus.screensaver_active = screensaver_active;
  assign bus.mode_change        = mode_change;
  assign bus.state_dbg          = state;
endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Directed bench for menu_nav_ctrl: driver pushes hand-computed expected
// outputs, a negedge monitor pops and compares them.
module tb_menu_nav_ctrl;
  import menu_pkg::*;

  // Clock / reset
  logic clk_menu = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_menu = ~clk_menu;

  menu_nav_if bus ();

  menu_nav_ctrl #(.NUM_ITEMS(5), .IDLE_TICKS(3000), .BLINK_HALF(5)) dut (
    .clk_menu (clk_menu),
    .reset    (reset),
    .bus      (bus)
  );

  // Button vectors {left, right, centre, down}
  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_L    = 4'b1000;
  localparam logic [3:0] B_R    = 4'b0100;
  localparam logic [3:0] B_C    = 4'b0010;
  localparam logic [3:0] B_D    = 4'b0001;
  // Output vector {box[2:0], mode[2:0], vis, hl, ss, mc}
  localparam logic [9:0] M_ALL  = 10'h3FF;
  localparam logic [9:0] M_NOHL = 10'h3FB;

  // Scoreboard: {mask, value}
  logic [19:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [9:0] pk(input int box, input int mode, input bit mv,
                                    input bit hl, input bit ss, input bit mc);
    return {3'(box), 3'(mode), mv, hl, ss, mc};
  endfunction

  // Driver tasks
  task automatic expect_now(input logic [9:0] v, input logic [9:0] m, input string nm);
    exp_q.push_back({m, v});
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [3:0] b, input logic tk);
    @(negedge clk_menu);
    {bus.pb_left, bus.pb_right, bus.pb_centre, bus.pb_down} = b;
    bus.tick_en = tk;
    @(posedge clk_menu);
    #1;
  endtask

  task automatic check_step(input logic [3:0] b, input logic tk, input logic [9:0] v,
                            input logic [9:0] m, input string nm);
    step(b, tk);
    expect_now(v, m, nm);
  endtask

  // One-cycle press, checked after its edge, then released
  task automatic press(input logic [3:0] b, input logic [9:0] v, input logic [9:0] m,
                       input string nm);
    check_step(b, 1'b0, v, m, nm);
    step(B_NONE, 1'b0);
  endtask

  // Monitor
  always @(negedge clk_menu) begin
    while (exp_q.size() > 0) begin : pop_one
      logic [19:0] e;
      logic [9:0]  act;
      string       nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.box_counter, bus.active_mode, bus.menu_visible, bus.highlight_on,
             bus.screensaver_active, bus.mode_change};
      n_vec++;
      if ((act & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_err++;
        $display("FAIL %s: got {box,mode,vis,hl,ss,mc}=%b_%b_%b%b%b%b want %b_%b_%b%b%b%b (mask %b)",
                 nm, act[9:7], act[6:4], act[3], act[2], act[1], act[0],
                 e[9:7], e[6:4], e[3], e[2], e[1], e[0], e[19:10]);
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    bus.tick_en = 0; bus.pb_left = 0; bus.pb_right = 0; bus.pb_centre = 0; bus.pb_down = 0;
    bus.menu_switch = 0; bus.switch_control_2 = 0;
    #1 expect_now(pk(0, 0, 1, 1, 0, 0), M_ALL, "reset_state");
    repeat (2) @(posedge clk_menu);
    @(negedge clk_menu);
    reset = 0;

    // Saturating right/left
    for (int k = 1; k <= 6; k++) press(B_R, pk((k < 4) ? k : 4, 0, 1, 1, 0, 0), M_ALL, "right_sat");
    for (int k = 1; k <= 5; k++) press(B_L, pk((k < 4) ? 4 - k : 0, 0, 1, 1, 0, 0), M_ALL, "left_sat");
    press(B_R, pk(1, 0, 1, 1, 0, 0), M_ALL, "right_to_1");
    press(B_R, pk(2, 0, 1, 1, 0, 0), M_ALL, "right_to_2");

    // Commit with menu hidden, then back to browse
    check_step(B_C, 0, pk(2, 2, 0, 1, 0, 1), M_ALL, "commit");
    check_step(B_NONE, 0, pk(2, 2, 0, 1, 0, 0), M_ALL, "commit_pulse_end");
    press(B_L, pk(2, 2, 0, 1, 0, 0), M_ALL, "run_left_ignored");
    press(B_C, pk(2, 2, 0, 1, 0, 0), M_ALL, "run_centre_ignored");
    press(B_D, pk(2, 2, 1, 1, 0, 0), M_ALL, "down_to_browse");
    press(B_R, pk(3, 2, 1, 1, 0, 0), M_ALL, "browse_right");
    press(B_D, pk(3, 2, 1, 1, 0, 0), M_ALL, "browse_down_ignored");

    // Run with menu shown
    check_step(B_C, 0, pk(3, 3, 0, 1, 0, 1), M_ALL, "commit_3");
    step(B_NONE, 0);
    bus.menu_switch = 1;
    check_step(B_NONE, 0, pk(3, 3, 1, 1, 0, 0), M_ALL, "run_menu_shown");
    press(B_L, pk(2, 3, 1, 1, 0, 0), M_ALL, "run_menu_left");
    check_step(B_C, 0, pk(2, 2, 1, 1, 0, 1), M_ALL, "run_menu_commit");
    check_step(B_NONE, 0, pk(2, 2, 1, 1, 0, 0), M_ALL, "run_menu_commit_end");
    press(B_R, pk(3, 2, 1, 1, 0, 0), M_ALL, "run_menu_right");
    press(B_D, pk(2, 2, 1, 1, 0, 0), M_ALL, "run_down_restores_box");
    bus.menu_switch = 0;

    // Lock
    bus.switch_control_2 = 1;
    for (int k = 0; k < 3; k++) press(B_R, pk(2, 2, 1, 1, 0, 0), M_ALL, "lock_right");
    check_step(B_C, 0, pk(2, 2, 1, 1, 0, 0), M_ALL, "lock_centre");
    step(B_NONE, 0);
    step(B_R, 0);
    bus.switch_control_2 = 0;
    check_step(B_R, 0, pk(2, 2, 1, 1, 0, 0), M_ALL, "held_through_unlock");
    step(B_NONE, 0);
    press(B_R, pk(3, 2, 1, 1, 0, 0), M_ALL, "after_unlock_right");

    // Blink
    for (int t = 1; t <= 10; t++)
      check_step(B_NONE, 1, pk(3, 2, 1, (t < 5) ? 1 : (t < 10) ? 0 : 1, 0, 0), M_ALL, "blink_idle");
    for (int t = 11; t <= 17; t++)
      check_step(B_NONE, 1, pk(3, 2, 1, (t < 15) ? 1 : 0, 0, 0), M_ALL, "blink_idle2");
    press(B_R, pk(4, 2, 1, 1, 0, 0), M_ALL, "blink_reload");
    for (int t = 1; t <= 5; t++)
      check_step(B_NONE, 1, pk(4, 2, 1, (t < 5) ? 1 : 0, 0, 0), M_ALL, "blink_after_reload");

    // Screensaver from BROWSE
    press(B_L, pk(3, 2, 1, 1, 0, 0), M_ALL, "pre_idle_left");
    repeat (2998) step(B_NONE, 1);
    check_step(B_NONE, 1, pk(3, 2, 1, 0, 0, 0), M_NOHL, "idle_2999_no_ss");
    check_step(B_NONE, 1, pk(3, 2, 0, 0, 1, 0), M_NOHL, "idle_3000_ss");
    check_step(B_NONE, 1, pk(3, 2, 0, 0, 1, 0), M_NOHL, "ss_hold");
    press(B_R, pk(3, 2, 1, 0, 0, 0), M_NOHL, "ss_exit_consumed");
    press(B_R, pk(4, 2, 1, 1, 0, 0), M_ALL, "post_ss_right");

    // Screensaver from RUN, left via lock
    bus.menu_switch = 1;
    check_step(B_C, 0, pk(4, 4, 1, 1, 0, 1), M_ALL, "commit_4");
    step(B_NONE, 0);
    repeat (2999) step(B_NONE, 1);
    check_step(B_NONE, 1, pk(4, 4, 0, 0, 1, 0), M_NOHL, "run_idle_ss");
    bus.switch_control_2 = 1;
    check_step(B_NONE, 0, pk(4, 4, 1, 0, 0, 0), M_NOHL, "lock_exits_ss_to_run");
    bus.switch_control_2 = 0;

    // Async reset mid-RUN with mode 3
    press(B_L, pk(3, 4, 1, 1, 0, 0), M_ALL, "run_left_to_3");
    check_step(B_C, 0, pk(3, 3, 1, 1, 0, 1), M_ALL, "commit_3_again");
    step(B_NONE, 0);
    @(posedge clk_menu);
    #2 reset = 1;
    #1 expect_now(pk(0, 0, 1, 1, 0, 0), M_ALL, "async_reset_mid_run");
    @(negedge clk_menu);
    @(negedge clk_menu);
    reset = 0;
    bus.menu_switch = 0;
    press(B_R, pk(1, 0, 1, 1, 0, 0), M_ALL, "post_reset_right");

    @(negedge clk_menu);
    @(negedge clk_menu);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
